sram_fifo_out_queue: RTL and testbench

Per-queue output stage of the SRAM FIFO: sits directly downstream of the SRAM read arbiter, one instance per queue. Accepts that queue's slice of the arbiter's word bus and its valid bit, buffers words in a small on-chip FIFO, and drives one AXI4-Stream master port. Returns a `full` flag with burst headroom that the arbiter uses to stop selecting the queue.

---
 rtl/sram_fifo_pkg.sv | 39 +++
 rtl/sram_fifo_out_ram.sv | 31 +++
 rtl/sram_fifo_out_queue.sv | 149 ++++++++++++++
 tb/tb_sram_fifo_out_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared word layout, tkeep helper and output FSM encoding for the per-queue
// SRAM FIFO output stage.
package sram_fifo_pkg;

  localparam int KEEP_MAX = 256;

  typedef logic [0:0] out_state_t;
  localparam out_state_t ST_IDLE = 1'b0;
  localparam out_state_t ST_SEND = 1'b1;

  function automatic int word_width(input int tdw);
    return 8 * tdw + 9;
  endfunction

  function automatic int len_lsb(input int tdw);
    return 8 * tdw;
  endfunction

  function automatic int len_msb(input int tdw);
    return 8 * tdw + 7;
  endfunction

  function automatic int tlast_bit(input int tdw);
    return 8 * tdw + 8;
  endfunction

  // Lengths at or beyond the bus width saturate to all ones.
  function automatic logic [KEEP_MAX-1:0] keep_from_len(input logic last,
                                                        input logic [7:0] len,
                                                        input int tdw);
    logic [KEEP_MAX-1:0] keep;
    keep = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      keep[i] = (i < tdw) && (!last || (i <= int'(len)));
    end
    return keep;
  endfunction

endpackage

// File: rtl/sram_fifo_out_ram.sv
// Simple dual-port word store for the output FIFO; the read register doubles
// as the data half of the AXI output register, hence its reset.
module sram_fifo_out_ram #(
  parameter int WIDTH = 265,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_fifo_out_queue.sv
// Per-queue output stage: buffers arbiter words and drives one AXI4-Stream master.
// Define SRAM_FIFO_OUT_STORE_FWD_EN for store-and-forward; default is cut-through.
module sram_fifo_out_queue
  import sram_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 64,
  parameter int FULL_MARGIN = 16
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [8*TDATA_WIDTH+8:0]   din,
  input  logic                       din_valid,
  output logic                       full,
  output logic [8*TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int WW        = word_width(TDATA_WIDTH);
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int TLAST_BIT = tlast_bit(TDATA_WIDTH);
  localparam int LEN_LSB   = len_lsb(TDATA_WIDTH);
  localparam int LEN_MSB   = len_msb(TDATA_WIDTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d, pkt_q, pkt_d;
  logic [15:0]      drop_q, drop_d;
  logic             tvalid_q, tvalid_d;
  logic [DEPTH-1:0] last_flags_q;
  logic [WW-1:0]    head_word;
  logic [CW-1:0]    free_cnt;
  logic             wr_en, rd_en, drop_in, handshake, head_elig, head_last;

  assign wr_en     = din_valid && (occ_q != CW'(DEPTH));
  assign drop_in   = din_valid && (occ_q == CW'(DEPTH));
  assign handshake = tvalid_q && m_axis_tready;
  assign rd_en     = (!tvalid_q || handshake) && (occ_q != '0) && head_elig;

  // The RAM read is registered, so the head's tlast is mirrored in flops to
  // let pkt_count and the FSM react in the same cycle the head is loaded.
  always_ff @(posedge axi_aclk) begin
    if (wr_en) last_flags_q[wr_ptr_q] <= din[TLAST_BIT];
  end
  assign head_last = last_flags_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    drop_d   = drop_q;
    tvalid_d = tvalid_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    case ({wr_en && din[TLAST_BIT], rd_en && head_last})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase
    if (drop_in && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if (rd_en)          tvalid_d = 1'b1;
    else if (handshake) tvalid_d = 1'b0;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
      tvalid_q <= tvalid_d;
    end
  end

`ifdef SRAM_FIFO_OUT_STORE_FWD_EN
  // state   | meaning
  // IDLE    | no complete packet stored, head withheld
  // SEND    | complete packet(s) stored, head presented
  out_state_t state_q, state_d;
  logic       pkt_done;

  // A single-beat packet can be loaded in the very cycle IDLE would move to
  // SEND; it must not leave the FSM in SEND with nothing complete behind it.
  assign pkt_done  = rd_en && head_last && (pkt_d == '0);
  assign head_elig = (state_q == ST_SEND) || ((pkt_q != '0) && (occ_q != '0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if ((pkt_q != '0) && (occ_q != '0) && !pkt_done) state_d = ST_SEND;
      default: if (pkt_done) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end
`else
  assign head_elig = 1'b1;
`endif

  sram_fifo_out_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_resetn),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_word)
  );

  assign free_cnt      = CW'(DEPTH) - occ_q;
  assign full          = (free_cnt <= CW'(FULL_MARGIN));
  assign overflow      = (drop_q != 16'd0);
  assign drop_count    = drop_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = head_word[8*TDATA_WIDTH-1:0];
  assign m_axis_tlast  = tvalid_q && head_word[TLAST_BIT];
  assign m_axis_tkeep  = tvalid_q
                       ? TDATA_WIDTH'(keep_from_len(head_word[TLAST_BIT],
                                                    head_word[LEN_MSB:LEN_LSB],
                                                    TDATA_WIDTH))
                       : '0;

endmodule

// File: tb/tb_sram_fifo_out_queue.sv
// Self-checking bench for sram_fifo_out_queue: directed table, full/overflow
// and occupancy sequences, then randomized traffic against a queue model.
module tb_sram_fifo_out_queue;

  localparam int TW     = 32;
  localparam int DEPTH  = 64;
  localparam int MARGIN = 16;
  localparam int DW     = 8 * TW;
  localparam int WW     = DW + 9;
`ifdef SRAM_FIFO_OUT_STORE_FWD_EN
  localparam int PULL = 0;
`else
  localparam int PULL = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WW-1:0] din;
  logic          din_valid;
  logic          full;
  logic [DW-1:0] tdata;
  logic [TW-1:0] tkeep;
  logic          tlast, tvalid, tready, overflow;
  logic [15:0]   drop_count;

  int n_vec = 0;
  int n_err = 0;

  logic [WW-1:0] mq[$];
  bit            m_ov;
  logic [WW-1:0] m_out;
  int            m_drops;

  sram_fifo_out_queue #(.TDATA_WIDTH(TW), .DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .din           (din),
    .din_valid     (din_valid),
    .full          (full),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dv;
    bit          last;
    logic [7:0]  len;
    logic [31:0] tag;
    bit          rdy;
    bit          ev;
    bit          elast;
    logic [31:0] ekeep;
    logic [31:0] etag;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_word(input bit last, input logic [7:0] len,
                                            input logic [31:0] tag);
    return {last, len, {8{tag}}};
  endfunction

  function automatic logic [TW-1:0] exp_keep(input logic [WW-1:0] w);
    int len;
    len = int'(w[DW+7:DW]);
    if (!w[WW-1] || len >= TW - 1) return '1;
    return TW'((64'd1 << (len + 1)) - 64'd1);
  endfunction

  function automatic bit model_elig();
`ifdef SRAM_FIFO_OUT_STORE_FWD_EN
    foreach (mq[i]) if (mq[i][WW-1]) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov    = 1'b0;
    m_out   = '0;
    m_drops = 0;
  endtask

  // Evaluated on pre-edge state and inputs.
  task automatic model_step();
    int sz   = mq.size();
    bit hs   = m_ov && tready;
    bit load = (!m_ov || hs) && (sz > 0) && model_elig();
    bit push = din_valid && (sz < DEPTH);
    if (din_valid && sz >= DEPTH && m_drops < 65535) m_drops++;
    if (load) begin
      m_out = mq.pop_front();
      m_ov  = 1'b1;
    end else if (hs) begin
      m_ov = 1'b0;
    end
    if (push) mq.push_back(din);
  endtask

  task automatic model_check();
    check("tvalid", DW'(tvalid), DW'(m_ov));
    if (m_ov) begin
      check("tdata", tdata, m_out[DW-1:0]);
      check("tkeep", DW'(tkeep), DW'(exp_keep(m_out)));
      check("tlast", DW'(tlast), DW'(m_out[WW-1]));
    end
    check("full", DW'(full), DW'((DEPTH - mq.size()) <= MARGIN));
    check("overflow", DW'(overflow), DW'(m_drops != 0));
    check("drop_count", DW'(drop_count), DW'(m_drops));
  endtask

  task automatic check_reset_outputs();
    check("rst_tvalid", DW'(tvalid), '0);
    check("rst_tdata", tdata, '0);
    check("rst_tkeep", DW'(tkeep), '0);
    check("rst_tlast", DW'(tlast), '0);
    check("rst_full", DW'(full), '0);
    check("rst_overflow", DW'(overflow), '0);
    check("rst_drop_count", DW'(drop_count), '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    tready    = 1'b0;
    din       = '0;
    rst_n     = 1'b0;
    tick();
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write(input bit dv, input bit last, input logic [7:0] len,
                       input logic [31:0] tag, input bit rdy);
    din_valid = dv;
    din       = mk_word(last, len, tag);
    tready    = rdy;
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    tbl[0]  = '{1, 0, 8'h00, 32'hA0, 1, 0, 0, 32'h0,        32'h0};
    tbl[1]  = '{1, 0, 8'h00, 32'hB1, 1, 1, 0, 32'hFFFFFFFF, 32'hA0};
    tbl[2]  = '{1, 1, 8'h0F, 32'hC2, 1, 1, 0, 32'hFFFFFFFF, 32'hB1};
    tbl[3]  = '{0, 0, 8'h00, 32'h00, 1, 1, 1, 32'h0000FFFF, 32'hC2};
    tbl[4]  = '{0, 0, 8'h00, 32'h00, 1, 0, 0, 32'h0,        32'h0};
    tbl[5]  = '{1, 0, 8'h55, 32'hD3, 0, 0, 0, 32'h0,        32'h0};
    tbl[6]  = '{1, 1, 8'h03, 32'hE4, 0, 1, 0, 32'hFFFFFFFF, 32'hD3};
    tbl[7]  = '{0, 0, 8'h00, 32'h00, 0, 1, 0, 32'hFFFFFFFF, 32'hD3};
    tbl[8]  = '{0, 0, 8'h00, 32'h00, 0, 1, 0, 32'hFFFFFFFF, 32'hD3};
    tbl[9]  = '{0, 0, 8'h00, 32'h00, 0, 1, 0, 32'hFFFFFFFF, 32'hD3};
    tbl[10] = '{0, 0, 8'h00, 32'h00, 0, 1, 0, 32'hFFFFFFFF, 32'hD3};
    tbl[11] = '{0, 0, 8'h00, 32'h00, 1, 1, 1, 32'h0000000F, 32'hE4};
    tbl[12] = '{0, 0, 8'h00, 32'h00, 1, 0, 0, 32'h0,        32'h0};
    tbl[13] = '{1, 1, 8'h40, 32'hF5, 1, 0, 0, 32'h0,        32'h0};
    tbl[14] = '{0, 0, 8'h00, 32'h00, 1, 1, 1, 32'hFFFFFFFF, 32'hF5};
    tbl[15] = '{0, 0, 8'h00, 32'h00, 1, 0, 0, 32'h0,        32'h0};
    tbl[16] = '{1, 1, 8'h1E, 32'h96, 1, 0, 0, 32'h0,        32'h0};
    tbl[17] = '{0, 0, 8'h00, 32'h00, 1, 1, 1, 32'h7FFFFFFF, 32'h96};
    tbl[18] = '{0, 0, 8'h00, 32'h00, 1, 0, 0, 32'h0,        32'h0};

    // Directed packet timing, stalls and tkeep boundaries.
    do_reset();
`ifdef SRAM_FIFO_OUT_STORE_FWD_EN
    for (int i = 0; i < 4; i++) begin
      write(1, 0, 8'h00, 32'h10 + i, 1);
      check("sf_hold_tvalid", DW'(tvalid), '0);
    end
    write(1, 1, 8'h07, 32'h14, 1);
    check("sf_tlast_cycle_tvalid", DW'(tvalid), '0);
    write(0, 0, 8'h00, 32'h0, 1);
    check("sf_first_tvalid", DW'(tvalid), DW'(1));
    check("sf_first_tdata", DW'(tdata[31:0]), DW'(32'h10));
`else
    foreach (tbl[i]) begin
      write(tbl[i].dv, tbl[i].last, tbl[i].len, tbl[i].tag, tbl[i].rdy);
      check("tbl_tvalid", DW'(tvalid), DW'(tbl[i].ev));
      if (tbl[i].ev) begin
        check("tbl_tdata", tdata, {8{tbl[i].etag}});
        check("tbl_tlast", DW'(tlast), DW'(tbl[i].elast));
        check("tbl_tkeep", DW'(tkeep), DW'(tbl[i].ekeep));
      end
    end
`endif

    // Almost-full threshold, overflow and drop counting; the first word of a
    // cut-through run moves into the output register, shifting occupancy by one.
    do_reset();
    for (int k = 1; k <= DEPTH + PULL; k++) begin
      write(1, 0, 8'h00, k, 0);
      if (k == 47 + PULL) check("full_below", DW'(full), '0);
      if (k == 48 + PULL) check("full_rise", DW'(full), DW'(1));
    end
    check("no_overflow_at_depth", DW'(overflow), '0);
    check("no_drop_at_depth", DW'(drop_count), '0);
    write(1, 0, 8'h00, 32'hDEAD, 0);
    check("overflow_set", DW'(overflow), DW'(1));
    check("drop_one", DW'(drop_count), DW'(1));
    write(1, 0, 8'h00, 32'hBEEF, 0);
    check("drop_two", DW'(drop_count), DW'(2));
`ifndef SRAM_FIFO_OUT_STORE_FWD_EN
    check("stalled_head", DW'(tdata[31:0]), DW'(1));
`endif
    write(1, 0, 8'h00, 32'hCAFE, 1);
    check("read_no_room", DW'(drop_count), DW'(3));
    check("full_after_read", DW'(full), DW'(1));
`ifndef SRAM_FIFO_OUT_STORE_FWD_EN
    din_valid = 1'b0;
    for (int t = 2; t <= DEPTH + 1; t++) begin
      check("drain_tvalid", DW'(tvalid), DW'(1));
      check("drain_order", DW'(tdata[31:0]), DW'(t));
      tick();
    end
    check("drained_tvalid", DW'(tvalid), '0);
    check("drained_full", DW'(full), '0);
`endif

    // Simultaneous write and read leave occupancy unchanged.
    do_reset();
    for (int k = 0; k < 11; k++) write(1, 1, 8'h00, 32'h300 + k, 0);
    check("occ_10", DW'(dut.occ_q), DW'(10));
    write(1, 1, 8'h00, 32'h30B, 1);
    check("occ_10_rw", DW'(dut.occ_q), DW'(10));

    // Randomized traffic against the queue model, with an asynchronous reset mid-run.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int mode;
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        din_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
      end
      mode = (c / 256) % 4;
      case (mode)
        0:       begin din_valid = ($urandom_range(1) == 0); tready = ($urandom_range(9) != 0); end
        1:       begin din_valid = ($urandom_range(19) != 0); tready = ($urandom_range(9) < 3); end
        2:       begin din_valid = ($urandom_range(9) != 0); tready = 1'b1; end
        default: begin din_valid = ($urandom_range(9) < 3); tready = ($urandom_range(1) == 0); end
      endcase
      din = mk_word($urandom_range(3) == 0, 8'($urandom_range(255)), $urandom);
      model_step();
      tick();
      model_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
